vga_pixel_source: RTL and testbench

//  Downstream consumer of the baby VGA timing generator. Holds a double-buffered 32x16 1bpp framebuffer

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_fb_bank.sv | 25 ++
 rtl/vga_pixel_source.sv | 119 +++++++++++
 tb/tb_vga_pixel_source.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel source and its framebuffer banks.
package vga_pkg;

  localparam int COLS    = 32;
  localparam int ROWS    = 16;
  localparam int COLOR_W = 6;
  localparam int ROW_AW  = $clog2(ROWS);

  localparam logic [4:0] VGA_ADDR_COLOR = 5'd16;
  localparam logic [4:0] VGA_ADDR_CTRL  = 5'd17;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t DEFAULT_FG = 6'h3F;
  localparam color_t DEFAULT_BG = 6'h00;

  function automatic color_t pixel_color(input logic blank, input logic pix,
                                         input color_t fg, input color_t bg);
    if (blank) return '0;
    return pix ? fg : bg;
  endfunction

endpackage

// File: rtl/vga_fb_bank.sv
// One framebuffer bank: ROWS words of COLS bits, one synchronous write port and
// two asynchronous read ports (pixel fetch and CPU readback).
import vga_pkg::*;

module vga_fb_bank (
  input  logic              clk,
  input  logic              we,
  input  logic [ROW_AW-1:0] waddr,
  input  logic [COLS-1:0]   wdata,
  input  logic [ROW_AW-1:0] raddr_a,
  output logic [COLS-1:0]   rdata_a,
  input  logic [ROW_AW-1:0] raddr_b,
  output logic [COLS-1:0]   rdata_b
);

  logic [COLS-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/vga_pixel_source.sv
// Double-buffered 1bpp framebuffer to RRGGBB pixel source with a fixed 2-cycle
// pipeline; bank swaps are applied only on the vsync falling edge.
import vga_pkg::*;

module vga_pixel_source (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         x_pos,
  input  logic [3:0]         y_pos,
  input  logic               blank,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               wr_en,
  input  logic [4:0]         wr_addr,
  input  logic [31:0]        wr_data,
  input  logic [4:0]         rd_addr,
  output logic [31:0]        rd_data,
  output logic [COLOR_W-1:0] rgb,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               front_bank,
  output logic               swap_pending
);

  color_t fg, bg;

  // S1 registers
  logic [COLS-1:0] row_q;
  logic [4:0]      x_q;
  logic            inr_q, blank_q, hs_q, vs_q;

  logic [COLS-1:0] pix_row0, pix_row1, cpu_row0, cpu_row1;
  logic            wr_row, we0, we1, swap_req, swap_evt, in_range;

  assign wr_row   = wr_en && (wr_addr < VGA_ADDR_COLOR);
  // Only the back bank (!front_bank) is writable; bank 0 is back while bank 1 is shown.
  assign we0      = wr_row && front_bank;
  assign we1      = wr_row && !front_bank;
  assign swap_req = wr_en && (wr_addr == VGA_ADDR_CTRL) && wr_data[0];
  assign swap_evt = vs_q && !vsync;
  assign in_range = (32'(x_pos) < COLS) && (32'(y_pos) < ROWS);

  vga_fb_bank u_bank0 (
    .clk     (clk),
    .we      (we0),
    .waddr   (wr_addr[ROW_AW-1:0]),
    .wdata   (wr_data[COLS-1:0]),
    .raddr_a (y_pos[ROW_AW-1:0]),
    .rdata_a (pix_row0),
    .raddr_b (rd_addr[ROW_AW-1:0]),
    .rdata_b (cpu_row0)
  );

  vga_fb_bank u_bank1 (
    .clk     (clk),
    .we      (we1),
    .waddr   (wr_addr[ROW_AW-1:0]),
    .wdata   (wr_data[COLS-1:0]),
    .raddr_a (y_pos[ROW_AW-1:0]),
    .rdata_a (pix_row1),
    .raddr_b (rd_addr[ROW_AW-1:0]),
    .rdata_b (cpu_row1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fg           <= DEFAULT_FG;
      bg           <= DEFAULT_BG;
      front_bank   <= 1'b0;
      swap_pending <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == VGA_ADDR_COLOR)) begin
        fg <= wr_data[COLOR_W-1:0];
        bg <= wr_data[8 +: COLOR_W];
      end
      if (swap_evt && (swap_pending || swap_req)) begin
        front_bank   <= ~front_bank;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      x_q     <= '0;
      inr_q   <= 1'b0;
      blank_q <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      rgb     <= '0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      row_q   <= front_bank ? pix_row1 : pix_row0;
      x_q     <= x_pos;
      inr_q   <= in_range;
      blank_q <= blank;
      hs_q    <= hsync;
      vs_q    <= vsync;
      rgb     <= pixel_color(blank_q, inr_q && row_q[x_q], fg, bg);
      hsync_o <= hs_q;
      vsync_o <= vs_q;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_addr < VGA_ADDR_COLOR)
      rd_data = front_bank ? cpu_row0 : cpu_row1;
    else if (rd_addr == VGA_ADDR_COLOR)
      rd_data = {18'b0, bg, 2'b0, fg};
    else if (rd_addr == VGA_ADDR_CTRL)
      rd_data = {30'b0, swap_pending, front_bank};
  end

endmodule

// File: tb/tb_vga_pixel_source.sv
// Directed self-checking bench for vga_pixel_source.
module tb_vga_pixel_source;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  x_pos;
  logic [3:0]  y_pos;
  logic        blank, hsync, vsync;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [5:0]  rgb;
  logic        hsync_o, vsync_o, front_bank, swap_pending;

  int total = 0;
  int bad   = 0;

  vga_pixel_source dut (
    .clk          (clk),
    .rst          (rst),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .blank        (blank),
    .hsync        (hsync),
    .vsync        (vsync),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rgb          (rgb),
    .hsync_o      (hsync_o),
    .vsync_o      (vsync_o),
    .front_bank   (front_bank),
    .swap_pending (swap_pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic show(input logic [4:0] x, input logic [3:0] y);
    x_pos = x; y_pos = y; blank = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; x_pos = '0; y_pos = '0; blank = 1'b1; hsync = 1'b0; vsync = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); tick(); tick();
    total++; if (rgb !== 6'h00) begin bad++; $display("FAIL reset_rgb got=%h exp=00", rgb); end
    total++; if ({hsync_o, vsync_o} !== 2'b00) begin bad++; $display("FAIL reset_sync got=%b exp=00", {hsync_o, vsync_o}); end
    total++; if ({front_bank, swap_pending} !== 2'b00) begin bad++; $display("FAIL reset_ctrl got=%b exp=00", {front_bank, swap_pending}); end
    rd_addr = 5'd16; #1;
    total++; if (rd_data !== 32'h0000_003F) begin bad++; $display("FAIL reset_colors got=%h exp=0000003f", rd_data); end
    rd_addr = 5'd17; #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_ctrl_rd got=%h exp=00000000", rd_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_swap_display();
    wr(5'd3, 32'h0000_0001);
    wr(5'd17, 32'h1);
    total++; if (swap_pending !== 1'b1) begin bad++; $display("FAIL t1_pending got=%b exp=1", swap_pending); end
    vsync = 1'b1; tick();
    vsync = 1'b0; tick();
    total++; if ({front_bank, swap_pending} !== 2'b10) begin bad++; $display("FAIL t1_swapped got=%b exp=10", {front_bank, swap_pending}); end
    show(5'd0, 4'd3);
    total++; if (rgb !== 6'h3F) begin bad++; $display("FAIL t1_pix_set got=%h exp=3f", rgb); end
    show(5'd1, 4'd3);
    total++; if (rgb !== 6'h00) begin bad++; $display("FAIL t1_pix_clr got=%h exp=00", rgb); end
  endtask

  task automatic test_pipeline();
    logic [23:0] bp, hp, vp;
    logic pb, ph, pv;
    bp = 24'hC35A0F; hp = 24'h963CA5; vp = 24'hF00F33;
    pb = 1'b0; ph = 1'b0; pv = 1'b0;
    for (int i = 0; i < 24; i++) begin
      blank = bp[i]; hsync = hp[i]; vsync = vp[i];
      x_pos = 5'($urandom); y_pos = 4'($urandom);
      tick();
      if (i > 0) begin
        total++; if (hsync_o !== ph) begin bad++; $display("FAIL t2_hsync[%0d] got=%b exp=%b", i, hsync_o, ph); end
        total++; if (vsync_o !== pv) begin bad++; $display("FAIL t2_vsync[%0d] got=%b exp=%b", i, vsync_o, pv); end
        if (pb) begin
          total++; if (rgb !== 6'h00) begin bad++; $display("FAIL t2_blank_rgb[%0d] got=%h exp=00", i, rgb); end
        end
      end
      pb = bp[i]; ph = hp[i]; pv = vp[i];
    end
    hsync = 1'b0; vsync = 1'b0; blank = 1'b1;
    tick();
  endtask

  task automatic test_colors();
    wr(5'd16, 32'h0000_2A15);
    rd_addr = 5'd16; #1;
    total++; if (rd_data !== 32'h0000_2A15) begin bad++; $display("FAIL t3_color_rd got=%h exp=00002a15", rd_data); end
    rd_addr = 5'd18; #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL t3_unmapped_rd got=%h exp=00000000", rd_data); end
    show(5'd0, 4'd3);
    total++; if (rgb !== 6'h15) begin bad++; $display("FAIL t3_fg got=%h exp=15", rgb); end
    show(5'd1, 4'd3);
    total++; if (rgb !== 6'h2A) begin bad++; $display("FAIL t3_bg got=%h exp=2a", rgb); end
  endtask

  task automatic test_swap_timing();
    vsync = 1'b1; tick();
    wr(5'd17, 32'h1);
    total++; if ({front_bank, swap_pending} !== 2'b11) begin bad++; $display("FAIL t4_held got=%b exp=11", {front_bank, swap_pending}); end
    tick(); tick();
    total++; if ({front_bank, swap_pending} !== 2'b11) begin bad++; $display("FAIL t4_still_held got=%b exp=11", {front_bank, swap_pending}); end
    vsync = 1'b0; tick();
    total++; if ({front_bank, swap_pending} !== 2'b00) begin bad++; $display("FAIL t4_edge got=%b exp=00", {front_bank, swap_pending}); end
    vsync = 1'b1; tick();
    vsync = 1'b0; wr(5'd17, 32'h1);
    total++; if ({front_bank, swap_pending} !== 2'b10) begin bad++; $display("FAIL t4_same_cycle got=%b exp=10", {front_bank, swap_pending}); end
  endtask

  task automatic test_write_on_swap();
    wr(5'd5, 32'h0000_0010);
    vsync = 1'b1; tick();
    vsync = 1'b0; wr(5'd17, 32'h1);
    wr(5'd5, 32'hFFFF_FFFF);
    wr(5'd17, 32'h1);
    vsync = 1'b1; tick();
    vsync = 1'b0; wr(5'd5, 32'h8000_0002);
    total++; if ({front_bank, swap_pending} !== 2'b10) begin bad++; $display("FAIL t5_swap got=%b exp=10", {front_bank, swap_pending}); end
    rd_addr = 5'd5; #1;
    total++; if (rd_data !== 32'h0000_0010) begin bad++; $display("FAIL t5_back_rd got=%h exp=00000010", rd_data); end
    rd_addr = 5'd17; #1;
    total++; if (rd_data !== 32'h1) begin bad++; $display("FAIL t5_ctrl_rd got=%h exp=00000001", rd_data); end
    show(5'd1, 4'd5);
    total++; if (rgb !== 6'h15) begin bad++; $display("FAIL t5_x1 got=%h exp=15", rgb); end
    show(5'd0, 4'd5);
    total++; if (rgb !== 6'h2A) begin bad++; $display("FAIL t5_x0 got=%h exp=2a", rgb); end
    show(5'd31, 4'd5);
    total++; if (rgb !== 6'h15) begin bad++; $display("FAIL t5_x31 got=%h exp=15", rgb); end
  endtask

  task automatic test_reset_midline();
    hsync = 1'b1; vsync = 1'b1; x_pos = 5'd1; y_pos = 4'd5; blank = 1'b0;
    tick();
    wr(5'd17, 32'h1);
    tick();
    total++; if (swap_pending !== 1'b1) begin bad++; $display("FAIL t6_pending got=%b exp=1", swap_pending); end
    total++; if ({rgb, hsync_o, vsync_o} !== {6'h15, 2'b11}) begin bad++; $display("FAIL t6_active got=%h/%b%b exp=15/11", rgb, hsync_o, vsync_o); end
    rst = 1'b1; tick();
    total++; if ({rgb, hsync_o, vsync_o} !== 8'h00) begin bad++; $display("FAIL t6_flush got=%h/%b%b exp=00/00", rgb, hsync_o, vsync_o); end
    total++; if ({front_bank, swap_pending} !== 2'b00) begin bad++; $display("FAIL t6_ctrl got=%b exp=00", {front_bank, swap_pending}); end
    rd_addr = 5'd16; #1;
    total++; if (rd_data !== 32'h0000_003F) begin bad++; $display("FAIL t6_colors got=%h exp=0000003f", rd_data); end
    rst = 1'b0; x_pos = 5'd4; y_pos = 4'd5; blank = 1'b0;
    tick();
    total++; if (rgb !== 6'h00) begin bad++; $display("FAIL t6_first got=%h exp=00", rgb); end
    tick();
    total++; if (rgb !== 6'h3F) begin bad++; $display("FAIL t6_second got=%h exp=3f", rgb); end
  endtask

  initial begin
    test_reset();
    test_swap_display();
    test_pipeline();
    test_colors();
    test_swap_timing();
    test_write_on_swap();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
